// File: rtl/chess_pkg.sv
// chess_pkg: shared types for the board commit path.
//   piece_t       - piece codes (white 0-5, black 6-11, EMPTY 15)
//   update_kind_t - request kinds posted by game logic
//   update_req_t  - packed 12-bit request {kind, row, col, piece}
//   board_t/hl_t  - committed board / highlight arrays, indexed [row][col]
//   empty_board()/start_position() - reset images for the board
package chess_pkg;

  typedef enum logic [3:0] {
    W_PAWN = 4'd0, W_KNIGHT = 4'd1, W_BISHOP = 4'd2, W_ROOK = 4'd3,
    W_QUEEN = 4'd4, W_KING = 4'd5,
    B_PAWN = 4'd6, B_KNIGHT = 4'd7, B_BISHOP = 4'd8, B_ROOK = 4'd9,
    B_QUEEN = 4'd10, B_KING = 4'd11,
    EMPTY = 4'd15
  } piece_t;

  typedef enum logic [1:0] {
    PIECE_WR   = 2'd0,
    HL_SET     = 2'd1,
    HL_CLR     = 2'd2,
    HL_CLR_ALL = 2'd3
  } update_kind_t;

  typedef struct packed {
    update_kind_t kind;
    logic [2:0]   row;
    logic [2:0]   col;
    logic [3:0]   piece;
  } update_req_t;

  localparam int REQ_W = $bits(update_req_t);

  typedef logic [7:0][7:0][3:0] board_t;
  typedef logic [7:0][7:0]      hl_t;

  function automatic board_t empty_board();
    board_t b;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        b[r][c] = EMPTY;
    return b;
  endfunction

  // Back rank in file order R N B Q K B N R, as white codes; black adds 6.
  function automatic board_t start_position();
    board_t          b;
    logic [7:0][3:0] rank;
    rank = {W_ROOK, W_KNIGHT, W_BISHOP, W_KING, W_QUEEN, W_BISHOP, W_KNIGHT, W_ROOK};
    b = empty_board();
    for (int c = 0; c < 8; c++) begin
      b[0][c] = rank[c] + 4'd6;
      b[1][c] = B_PAWN;
      b[6][c] = W_PAWN;
      b[7][c] = rank[c];
    end
    return b;
  endfunction

endpackage

// File: rtl/commit_fifo.sv
// commit_fifo: synchronous FIFO holding pending board updates.
//   i_clk, i_rst_n     - clock, asynchronous active-low reset
//   i_push, i_din      - write strobe / data (ignored when full)
//   i_pop, o_dout      - read strobe (ignored when empty) / head entry
//   o_full, o_empty    - status
//   o_count            - occupancy, log2(DEPTH)+1 bits
module commit_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 12
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_din,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_dout,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push_acc, w_pop_acc;

  assign o_full     = (r_count == CW'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_dout     = r_mem[r_rd_ptr];
  assign w_push_acc = i_push && !o_full;
  assign w_pop_acc  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push_acc) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointers are exactly log2(DEPTH) bits, so +1 wraps on its own.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_acc)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_acc, w_pop_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/board_commit_ctrl.sv
// board_commit_ctrl: owns the committed board / highlight arrays for the
// chess screen and applies queued updates only during vertical blanking.
//   vga_clk, reset_n           - pixel clock, asynchronous active-low reset
//   hcount, vcount             - shared raster position
//   req_valid/req_ready        - update request handshake
//   req_kind/row/col/piece     - update request payload
//   board, square_highlight    - committed arrays, [row][col]
//   frame_tick                 - combinational pulse at vblank start
//   commit_busy                - high while in COMMIT
//   overflow                   - sticky, request seen while FIFO full
// Build option: define INIT_POSITION_EN to reset into the standard start
// position instead of an empty board.
module board_commit_ctrl
  import chess_pkg::*;
#(
  parameter int FIFO_DEPTH    = 8,
  parameter int SCREEN_HEIGHT = 480,
  parameter int V_TOTAL       = 525
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_kind,
  input  logic [2:0] req_row,
  input  logic [2:0] req_col,
  input  logic [3:0] req_piece,
  output board_t     board,
  output hl_t        square_highlight,
  output logic       frame_tick,
  output logic       commit_busy,
  output logic       overflow
);
  localparam int         CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [9:0] VB_FIRST = 10'(SCREEN_HEIGHT);
  localparam logic [9:0] VB_END   = 10'(V_TOTAL);

  localparam logic [1:0] S_ACTIVE   = 2'd0;
  localparam logic [1:0] S_COMMIT   = 2'd1;
  localparam logic [1:0] S_WAIT_VIS = 2'd2;

`ifdef INIT_POSITION_EN
  localparam board_t BOARD_RST = start_position();
`else
  localparam board_t BOARD_RST = empty_board();
`endif

  logic [1:0]       r_state, w_state_nxt;
  board_t           r_board;
  hl_t              r_hl;
  logic             r_overflow;
  logic             w_full, w_empty, w_push, w_pop;
  logic [CW-1:0]    w_count;
  logic [REQ_W-1:0] w_head_raw;
  update_req_t      w_req_in, w_head;
  logic             w_vblank, w_vblank_start, w_vis_start;

  assign w_vblank       = (vcount >= VB_FIRST) && (vcount < VB_END);
  assign w_vblank_start = (hcount == 10'd0) && (vcount == VB_FIRST);
  assign w_vis_start    = (hcount == 10'd0) && (vcount == 10'd0);

  assign req_ready        = !w_full;
  assign w_push           = req_valid && req_ready;
  assign w_req_in         = {req_kind, req_row, req_col, req_piece};
  assign w_head           = w_head_raw;
  // Pops are gated by vblank so the arrays can never move during the
  // visible region, even on the cycle COMMIT is leaving.
  assign w_pop            = (r_state == S_COMMIT) && !w_empty && w_vblank;

  assign frame_tick       = w_vblank_start;
  assign commit_busy      = (r_state == S_COMMIT);
  assign overflow         = r_overflow;
  assign board            = r_board;
  assign square_highlight = r_hl;

  commit_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(REQ_W)) u_fifo (
    .i_clk   (vga_clk),
    .i_rst_n (reset_n),
    .i_push  (w_push),
    .i_din   (w_req_in),
    .i_pop   (w_pop),
    .o_dout  (w_head_raw),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_ACTIVE: begin
        if (w_vblank_start) w_state_nxt = w_empty ? S_WAIT_VIS : S_COMMIT;
      end
      S_COMMIT: begin
        // Leaving on the very first visible pixel: that is the point
        // WAIT_VIS waits for, so go straight to ACTIVE rather than
        // sleeping through the next frame's blanking.
        if (!w_vblank)
          w_state_nxt = w_vis_start ? S_ACTIVE : S_WAIT_VIS;
        else if (!w_push && (w_empty || w_count == CW'(1)))
          w_state_nxt = S_WAIT_VIS;
      end
      S_WAIT_VIS: begin
        if (w_vis_start) w_state_nxt = S_ACTIVE;
      end
      default: w_state_nxt = S_ACTIVE;
    endcase
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_ACTIVE;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (req_valid && w_full) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_board <= BOARD_RST;
      r_hl    <= '0;
    end else if (w_pop) begin
      case (w_head.kind)
        PIECE_WR:   r_board[w_head.row][w_head.col] <= w_head.piece;
        HL_SET:     r_hl[w_head.row][w_head.col]    <= 1'b1;
        HL_CLR:     r_hl[w_head.row][w_head.col]    <= 1'b0;
        HL_CLR_ALL: r_hl                            <= '0;
        default:    r_hl                            <= r_hl;
      endcase
    end
  end
endmodule

// File: doc/board_commit_ctrl.md
Name: board_commit_ctrl

Overview:
Owns the 8x8 board and square_highlight arrays that drive the CHESS_SCREEN renderer. Game logic posts update requests through a valid/ready FIFO. The block applies the updates only during vertical blanking, so a frame never shows a half-applied move.
Sits between game logic and the screen generator, on vga_clk, and uses the same hcount/vcount as the renderer.

Parameters:
FIFO_DEPTH, 8, number of pending update entries (power of two, >=2)
SCREEN_HEIGHT, 480, first vcount value that counts as vertical blanking
V_TOTAL, 525, vcount wrap value; vblank is SCREEN_HEIGHT <= vcount < V_TOTAL

Ports:
vga_clk  in  1  pixel clock, 25 MHz
reset_n  in  1  asynchronous active-low reset
hcount  in  10  horizontal pixel count
vcount  in  10  vertical pixel count
req_valid  in  1  update request valid
req_ready  out  1  FIFO can accept a request
req_kind  in  2  update_kind_t: PIECE_WR=0, HL_SET=1, HL_CLR=2, HL_CLR_ALL=3
req_row  in  3  target row (0 = top of screen)
req_col  in  3  target column
req_piece  in  4  piece code, used only for PIECE_WR (0-11 = piece, 15 = empty)
board  out  4x[8][8]  committed piece array
square_highlight  out  1x[8][8]  committed highlight array
frame_tick  out  1  one-cycle pulse when vblank begins
commit_busy  out  1  high while in COMMIT
overflow  out  1  sticky; set when req_valid arrives while FIFO is full; cleared only by reset

Behaviour:
- Reset (asynchronous, reset_n low):
  - Every board entry = EMPTY (4'hF); every highlight = 0.
  - FIFO empty; req_ready = 1; frame_tick = 0; commit_busy = 0; overflow = 0; FSM in ACTIVE.
  - Reset asserted mid-COMMIT discards all pending entries; squares already committed revert to reset values.
- Handshake:
  - A request is accepted on a vga_clk edge where req_valid && req_ready.
  - req_ready = !full, registered-free (combinational from the FIFO count).
  - Push and pop in the same cycle are legal; the count is unchanged.
  - When full, the request is not accepted and overflow is set.
- vblank_start: hcount == 0 && vcount == SCREEN_HEIGHT. frame_tick is asserted that same cycle; it has no latency from the counts.
- FSM:
  - ACTIVE: no commits. On vblank_start: go to COMMIT if the FIFO is non-empty, else go to WAIT_VIS.
  - COMMIT: pop one entry per cycle and apply it; commit_busy = 1.
    - PIECE_WR writes board[row][col] = req_piece.
    - HL_SET / HL_CLR write square_highlight[row][col] = 1 / 0.
    - HL_CLR_ALL zeroes all 64 highlights in one cycle.
    - Exit to WAIT_VIS when the FIFO becomes empty, or when vcount reaches 0 (vblank over). Any remaining entries stay queued for the next frame.
  - WAIT_VIS: return to ACTIVE when vcount == 0 && hcount == 0. Prevents a second commit in the same blanking interval.
- Ordering: entries commit strictly in FIFO order. A later write to the same square overwrites an earlier one within the same commit burst.
- Entries accepted during COMMIT can be popped in the same burst, as long as vblank has not ended.
- Output latency: board/highlight change one edge after the pop; they never change while vcount < SCREEN_HEIGHT.
- FIFO pointers are log2(FIFO_DEPTH) bits wide and wrap. The count is log2(FIFO_DEPTH)+1 bits wide.

Optional Feature:
INIT_POSITION_EN
- Defined: reset loads the standard starting position.
  - Row 0: B_ROOK B_KNIGHT B_BISHOP B_QUEEN B_KING B_BISHOP B_KNIGHT B_ROOK.
  - Row 1: B_PAWN. Row 6: W_PAWN. Row 7: white back rank in the same file order.
  - Rows 2-5: EMPTY.
- Undefined: reset loads all EMPTY as above.

Decomposition:
- Package chess_pkg holds:
  - piece_t codes: W_PAWN..W_KING = 0-5, B_PAWN..B_KING = 6-11, EMPTY = 15
  - update_kind_t
  - the packed request struct {kind, row, col, piece}
- One sub-module: commit_fifo, a synchronous FIFO (FIFO_DEPTH x 12 bits) with push/pop/full/empty/count, asynchronous active-low reset.

Test Plan:
- Reset, then sweep one frame with no requests -> board all 15 (or the start position with INIT_POSITION_EN); highlights all 0; frame_tick pulses once at vcount=480, hcount=0.
- Push PIECE_WR(row 6, col 4, piece 15) and PIECE_WR(4, 4, 0) at vcount=100 -> board unchanged until vcount=480; board[6][4]=15 and board[4][4]=0 on the 2nd and 3rd edges after vblank_start; commit_busy high for 2 cycles.
- Push 9 requests with FIFO_DEPTH=8 and no vblank -> req_ready=0 after 8 accepts; 9th held off; overflow=1 and remains 1 after the next commit.
- Push HL_SET(2,3) then HL_CLR_ALL then HL_SET(5,5) -> after commit only square_highlight[5][5]=1.
- Force vcount to wrap to 0 after 2 of 5 pops -> 3 entries remain queued; they commit at the next vblank_start, and no commit occurs in the intervening visible lines.
- Assert reset_n low mid-COMMIT -> FIFO empty, outputs at reset values immediately (asynchronously), overflow=0.
